// File: rtl/ctrl_cycle_scheduler.sv
// Per-sync control-cycle sequencer: ADC delay, ADC conversion, control-law calculation, PWM update.
// Also flags handshake timeouts and counts overruns (a sync edge that arrives before the cycle has finished).
module ctrl_cycle_scheduler #(
  parameter int DLY_W = 16,
  parameter int TO_W  = 16,
  parameter int CNT_W = 8
) (
  input  logic             clock_sync,
  input  logic             reset,
  input  logic             enable,
  input  logic             master_sync,
  input  logic [DLY_W-1:0] adc_delay,
  input  logic [TO_W-1:0]  timeout,
  input  logic             adc_done,
  input  logic             calc_done,
  input  logic             clear_flags,
  output logic             adc_start,
  output logic             calc_start,
  output logic             pwm_update,
  output logic             cycle_done,
  output logic             busy,
  output logic [1:0]       state,
  output logic             timeout_flag,
  output logic [CNT_W-1:0] overrun_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DELAY     = 2'd1,
    ADC_WAIT  = 2'd2,
    CALC_WAIT = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [DLY_W-1:0]   dly_cnt_q, dly_cnt_d;
  logic [TO_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic               sync_prev_q;
  logic               armed_q;
  logic               adc_start_q, adc_start_d;
  logic               calc_start_q, calc_start_d;
  logic               pwm_update_q, pwm_update_d;
  logic               busy_q, busy_d;
  logic               timeout_flag_q, timeout_flag_d;
  logic [CNT_W-1:0]   overrun_cnt_q, overrun_cnt_d;
  logic               sync_edge;
  logic               to_hit;
  logic               timeout_evt;
  logic               overrun_evt;

  // armed_q stops a sync that is already high when reset is released from being taken as a new edge
  always_comb begin
    sync_edge    = master_sync & ~sync_prev_q & armed_q;
    to_hit       = (timeout != '0) && (wait_cnt_q == timeout - TO_W'(1));
    state_d      = state_q;
    dly_cnt_d    = dly_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    adc_start_d  = 1'b0;
    calc_start_d = 1'b0;
    pwm_update_d = 1'b0;
    timeout_evt  = 1'b0;
    overrun_evt  = 1'b0;

    if (!enable) begin
      state_d = IDLE;
    end else if (sync_edge) begin
      overrun_evt = (state_q != IDLE);
      if (adc_delay == '0) begin
        state_d     = ADC_WAIT;
        adc_start_d = 1'b1;
        wait_cnt_d  = '0;
      end else begin
        state_d   = DELAY;
        dly_cnt_d = adc_delay;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        DELAY: begin
          if (dly_cnt_q <= DLY_W'(1)) begin
            state_d     = ADC_WAIT;
            adc_start_d = 1'b1;
            wait_cnt_d  = '0;
          end else begin
            dly_cnt_d = dly_cnt_q - DLY_W'(1);
          end
        end
        // A done is ignored in the cycle its start pulse is high.
        ADC_WAIT: begin
          if (to_hit) begin
            state_d     = IDLE;
            timeout_evt = 1'b1;
          end else if (adc_done && !adc_start_q) begin
            state_d      = CALC_WAIT;
            calc_start_d = 1'b1;
            wait_cnt_d   = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + TO_W'(1);
          end
        end
        CALC_WAIT: begin
          if (to_hit) begin
            state_d     = IDLE;
            timeout_evt = 1'b1;
          end else if (calc_done && !calc_start_q) begin
            state_d      = IDLE;
            pwm_update_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + TO_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);

    // A new event wins over clear_flags in the same cycle
    if (clear_flags) begin
      timeout_flag_d = timeout_evt;
      overrun_cnt_d  = overrun_evt ? CNT_W'(1) : '0;
    end else begin
      timeout_flag_d = timeout_flag_q | timeout_evt;
      overrun_cnt_d  = (overrun_evt && !(&overrun_cnt_q)) ? overrun_cnt_q + CNT_W'(1)
                                                          : overrun_cnt_q;
    end
  end

  always_ff @(posedge clock_sync) begin
    if (reset) begin
      state_q        <= IDLE;
      dly_cnt_q      <= '0;
      wait_cnt_q     <= '0;
      sync_prev_q    <= 1'b0;
      armed_q        <= ~master_sync;
      adc_start_q    <= 1'b0;
      calc_start_q   <= 1'b0;
      pwm_update_q   <= 1'b0;
      busy_q         <= 1'b0;
      timeout_flag_q <= 1'b0;
      overrun_cnt_q  <= '0;
    end else begin
      state_q        <= state_d;
      dly_cnt_q      <= dly_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      sync_prev_q    <= master_sync;
      armed_q        <= armed_q | ~master_sync;
      adc_start_q    <= adc_start_d;
      calc_start_q   <= calc_start_d;
      pwm_update_q   <= pwm_update_d;
      busy_q         <= busy_d;
      timeout_flag_q <= timeout_flag_d;
      overrun_cnt_q  <= overrun_cnt_d;
    end
  end

  assign adc_start    = adc_start_q;
  assign calc_start   = calc_start_q;
  assign pwm_update   = pwm_update_q;
  assign cycle_done   = pwm_update_q;
  assign busy         = busy_q;
  assign state        = state_q;
  assign timeout_flag = timeout_flag_q;
  assign overrun_cnt  = overrun_cnt_q;

endmodule

// File: tb/tb_ctrl_cycle_scheduler.sv
// Directed testbench for ctrl_cycle_scheduler; cycle n is the interval after the n-th edge following the sync edge k.
// Inputs are driven and outputs sampled 1 ns after each rising clock edge.
module tb_ctrl_cycle_scheduler;

  logic        clock_sync = 1'b0;
  logic        reset, enable, master_sync;
  logic [15:0] adc_delay, timeout;
  logic        adc_done, calc_done, clear_flags;
  logic        adc_start, calc_start, pwm_update, cycle_done, busy;
  logic [1:0]  state;
  logic        timeout_flag;
  logic [7:0]  overrun_cnt;

  int errors = 0;
  int checks = 0;

  ctrl_cycle_scheduler #(.DLY_W(16), .TO_W(16), .CNT_W(8)) dut (
    .clock_sync  (clock_sync),
    .reset       (reset),
    .enable      (enable),
    .master_sync (master_sync),
    .adc_delay   (adc_delay),
    .timeout     (timeout),
    .adc_done    (adc_done),
    .calc_done   (calc_done),
    .clear_flags (clear_flags),
    .adc_start   (adc_start),
    .calc_start  (calc_start),
    .pwm_update  (pwm_update),
    .cycle_done  (cycle_done),
    .busy        (busy),
    .state       (state),
    .timeout_flag(timeout_flag),
    .overrun_cnt (overrun_cnt)
  );

  always #5 clock_sync = ~clock_sync;

  task automatic step();
    @(posedge clock_sync);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; master_sync = 1'b0; adc_delay = 16'd5; timeout = 16'd0;
    adc_done = 1'b0; calc_done = 1'b0; clear_flags = 1'b0;
    step(); step();
    checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL rst_state got=%0d want=0", state); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got=%0b want=0", busy); end
    checks++; if (adc_start !== 1'b0) begin errors++; $display("[TB] FAIL rst_adc_start got=%0b want=0", adc_start); end
    checks++; if (calc_start !== 1'b0) begin errors++; $display("[TB] FAIL rst_calc_start got=%0b want=0", calc_start); end
    checks++; if (pwm_update !== 1'b0) begin errors++; $display("[TB] FAIL rst_pwm got=%0b want=0", pwm_update); end
    checks++; if (cycle_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_cycle_done got=%0b want=0", cycle_done); end
    checks++; if (timeout_flag !== 1'b0) begin errors++; $display("[TB] FAIL rst_flag got=%0b want=0", timeout_flag); end
    checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("[TB] FAIL rst_ovr got=%0d want=0", overrun_cnt); end
    reset = 1'b0;
    step(); step();
    checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL rst_idle_after got=%0d want=0", state); end
  endtask

  // adc_delay=5, 20-cycle sync, adc_done at k+9, calc_done 4 cycles after calc_start
  task automatic test_basic_cycle();
    adc_delay = 16'd5; timeout = 16'd0;
    for (int n = 0; n <= 20; n++) begin
      if (n > 0) begin
        checks++; if (adc_start !== (n == 6)) begin errors++; $display("[TB] FAIL t1_adc_start n=%0d got=%0b want=%0b", n, adc_start, (n == 6)); end
        checks++; if (calc_start !== (n == 10)) begin errors++; $display("[TB] FAIL t1_calc_start n=%0d got=%0b want=%0b", n, calc_start, (n == 10)); end
        checks++; if (pwm_update !== (n == 15)) begin errors++; $display("[TB] FAIL t1_pwm n=%0d got=%0b want=%0b", n, pwm_update, (n == 15)); end
        checks++; if (cycle_done !== (n == 15)) begin errors++; $display("[TB] FAIL t1_cycle_done n=%0d got=%0b want=%0b", n, cycle_done, (n == 15)); end
        if (n != 15) begin
          checks++; if (busy !== (n <= 14)) begin errors++; $display("[TB] FAIL t1_busy n=%0d got=%0b want=%0b", n, busy, (n <= 14)); end
        end
        if (n == 1) begin checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL t1_state_delay got=%0d want=1", state); end end
        if (n == 6) begin checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL t1_state_adc got=%0d want=2", state); end end
        if (n == 10) begin checks++; if (state !== 2'd3) begin errors++; $display("[TB] FAIL t1_state_calc got=%0d want=3", state); end end
        if (n == 16) begin checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL t1_state_idle got=%0d want=0", state); end end
      end
      master_sync = (n < 20);
      adc_done    = (n == 9);
      calc_done   = (n == 14);
      step();
    end
    master_sync = 1'b0; adc_done = 1'b0; calc_done = 1'b0;
  endtask

  // adc_delay=0 and adc_done held high: done must be ignored in the adc_start cycle
  task automatic test_zero_delay();
    adc_delay = 16'd0; timeout = 16'd0;
    for (int n = 0; n <= 7; n++) begin
      if (n > 0) begin
        checks++; if (adc_start !== (n == 1)) begin errors++; $display("[TB] FAIL t2_adc_start n=%0d got=%0b want=%0b", n, adc_start, (n == 1)); end
        checks++; if (calc_start !== (n == 3)) begin errors++; $display("[TB] FAIL t2_calc_start n=%0d got=%0b want=%0b", n, calc_start, (n == 3)); end
        checks++; if (pwm_update !== (n == 5)) begin errors++; $display("[TB] FAIL t2_pwm n=%0d got=%0b want=%0b", n, pwm_update, (n == 5)); end
        if (n == 2) begin checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL t2_state_adc got=%0d want=2", state); end end
        if (n == 4) begin checks++; if (state !== 2'd3) begin errors++; $display("[TB] FAIL t2_state_calc got=%0d want=3", state); end end
        if (n == 6) begin checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL t2_state_idle got=%0d want=0", state); end end
      end
      master_sync = (n < 2);
      adc_done    = 1'b1;
      calc_done   = (n == 4);
      step();
    end
    master_sync = 1'b0; adc_done = 1'b0; calc_done = 1'b0;
    step();
  endtask

  // timeout=8 with adc_done never asserted
  task automatic test_timeout();
    logic seen_calc, seen_pwm;
    seen_calc = 1'b0; seen_pwm = 1'b0;
    adc_delay = 16'd2; timeout = 16'd8;
    for (int n = 0; n <= 13; n++) begin
      if (n > 0) begin
        seen_calc = seen_calc | calc_start;
        seen_pwm  = seen_pwm | pwm_update;
        if (n == 3) begin checks++; if (adc_start !== 1'b1) begin errors++; $display("[TB] FAIL t3_adc_start got=%0b want=1", adc_start); end end
        if (n == 10) begin
          checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL t3_state_last_wait got=%0d want=2", state); end
          checks++; if (timeout_flag !== 1'b0) begin errors++; $display("[TB] FAIL t3_flag_early got=%0b want=0", timeout_flag); end
        end
        if (n == 11) begin
          checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL t3_state_idle got=%0d want=0", state); end
          checks++; if (timeout_flag !== 1'b1) begin errors++; $display("[TB] FAIL t3_flag_set got=%0b want=1", timeout_flag); end
        end
      end
      master_sync = (n == 0);
      step();
    end
    checks++; if (seen_calc !== 1'b0) begin errors++; $display("[TB] FAIL t3_no_calc_start got=%0b want=0", seen_calc); end
    checks++; if (seen_pwm !== 1'b0) begin errors++; $display("[TB] FAIL t3_no_pwm got=%0b want=0", seen_pwm); end
    checks++; if (timeout_flag !== 1'b1) begin errors++; $display("[TB] FAIL t3_flag_sticky got=%0b want=1", timeout_flag); end
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    checks++; if (timeout_flag !== 1'b0) begin errors++; $display("[TB] FAIL t3_flag_clear got=%0b want=0", timeout_flag); end
    timeout = 16'd0;
  endtask

  // Edge during CALC_WAIT (with a coincident calc_done), then saturation and clear-vs-overrun
  task automatic test_overrun();
    logic seen_pwm;
    seen_pwm = 1'b0;
    adc_delay = 16'd3; timeout = 16'd0;
    for (int n = 0; n <= 12; n++) begin
      if (n > 0) begin
        seen_pwm = seen_pwm | pwm_update;
        if (n == 4) begin checks++; if (adc_start !== 1'b1) begin errors++; $display("[TB] FAIL t4_adc_start got=%0b want=1", adc_start); end end
        if (n == 6) begin checks++; if (state !== 2'd3) begin errors++; $display("[TB] FAIL t4_state_calc got=%0d want=3", state); end end
        if (n == 9) begin
          checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL t4_restart_delay got=%0d want=1", state); end
          checks++; if (overrun_cnt !== 8'd1) begin errors++; $display("[TB] FAIL t4_ovr_first got=%0d want=1", overrun_cnt); end
        end
      end
      master_sync = (n == 0) || (n == 8);
      adc_done    = (n == 5);
      calc_done   = (n == 8);
      step();
    end
    adc_done = 1'b0; calc_done = 1'b0;
    checks++; if (seen_pwm !== 1'b0) begin errors++; $display("[TB] FAIL t4_no_pwm got=%0b want=0", seen_pwm); end
    for (int i = 0; i < 254; i++) begin
      master_sync = 1'b1; step();
      master_sync = 1'b0; step();
    end
    checks++; if (overrun_cnt !== 8'd255) begin errors++; $display("[TB] FAIL t4_ovr_reach_max got=%0d want=255", overrun_cnt); end
    master_sync = 1'b1; step();
    master_sync = 1'b0; step();
    checks++; if (overrun_cnt !== 8'd255) begin errors++; $display("[TB] FAIL t4_ovr_saturate got=%0d want=255", overrun_cnt); end
    master_sync = 1'b1; clear_flags = 1'b1;
    step();
    master_sync = 1'b0; clear_flags = 1'b0;
    checks++; if (overrun_cnt !== 8'd1) begin errors++; $display("[TB] FAIL t4_clear_vs_ovr got=%0d want=1", overrun_cnt); end
    step();
    enable = 1'b0; step();
    enable = 1'b1;
    checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL t4_flush_idle got=%0d want=0", state); end
    step();
  endtask

  // enable dropped in ADC_WAIT, then re-enabled in the same cycle as a new edge
  task automatic test_enable();
    logic seen_pulse;
    seen_pulse = 1'b0;
    adc_delay = 16'd1; timeout = 16'd0;
    for (int n = 0; n <= 13; n++) begin
      if (n > 0) begin
        if (n >= 4 && n <= 6) seen_pulse = seen_pulse | adc_start | calc_start | pwm_update;
        if (n == 2) begin checks++; if (adc_start !== 1'b1) begin errors++; $display("[TB] FAIL t5_adc_start1 got=%0b want=1", adc_start); end end
        if (n == 4) begin
          checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL t5_disable_idle got=%0d want=0", state); end
          checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL t5_disable_busy got=%0b want=0", busy); end
          checks++; if (overrun_cnt !== 8'd1) begin errors++; $display("[TB] FAIL t5_ovr_held got=%0d want=1", overrun_cnt); end
        end
        if (n == 7) begin checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL t5_reenable_delay got=%0d want=1", state); end end
        if (n == 8) begin checks++; if (adc_start !== 1'b1) begin errors++; $display("[TB] FAIL t5_adc_start2 got=%0b want=1", adc_start); end end
        if (n == 10) begin checks++; if (calc_start !== 1'b1) begin errors++; $display("[TB] FAIL t5_calc_start got=%0b want=1", calc_start); end end
        if (n == 12) begin checks++; if (pwm_update !== 1'b1) begin errors++; $display("[TB] FAIL t5_pwm got=%0b want=1", pwm_update); end end
      end
      master_sync = (n == 0) || (n == 6);
      enable      = !(n >= 3 && n <= 5);
      adc_done    = (n == 3) || (n == 4) || (n == 9);
      calc_done   = (n == 11);
      step();
    end
    enable = 1'b1; master_sync = 1'b0; adc_done = 1'b0; calc_done = 1'b0;
    checks++; if (seen_pulse !== 1'b0) begin errors++; $display("[TB] FAIL t5_no_pulses got=%0b want=0", seen_pulse); end
  endtask

  // Reset in CALC_WAIT with master_sync held high across reset release
  task automatic test_reset_mid_cycle();
    adc_delay = 16'd0; timeout = 16'd0;
    for (int n = 0; n <= 12; n++) begin
      if (n == 3) begin checks++; if (state !== 2'd3) begin errors++; $display("[TB] FAIL t6_state_calc got=%0d want=3", state); end end
      if (n == 5) begin
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL t6_rst_state got=%0d want=0", state); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL t6_rst_busy got=%0b want=0", busy); end
        checks++; if ((adc_start | calc_start | pwm_update | cycle_done) !== 1'b0) begin errors++; $display("[TB] FAIL t6_rst_pulses got=%0b want=0", adc_start | calc_start | pwm_update | cycle_done); end
        checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("[TB] FAIL t6_rst_ovr got=%0d want=0", overrun_cnt); end
      end
      if (n >= 6 && n <= 10) begin checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL t6_no_edge n=%0d got=%0d want=0", n, state); end end
      if (n == 11) begin
        checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL t6_edge_after_low got=%0d want=2", state); end
        checks++; if (adc_start !== 1'b1) begin errors++; $display("[TB] FAIL t6_adc_start got=%0b want=1", adc_start); end
      end
      master_sync = (n == 0) || (n >= 4 && n <= 8) || (n >= 10);
      reset       = (n == 4);
      adc_done    = (n == 2);
      step();
    end
    master_sync = 1'b0; adc_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_basic_cycle();
    test_zero_delay();
    test_timeout();
    test_overrun();
    test_enable();
    test_reset_mid_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
